// File: rtl/inst_fetcher.sv
// inst_fetcher: instruction fetch stage.
//   Owns the fetch PC, issues one icache request at a time, decodes branch/JAL targets for the
//   branch predictor and pushes {inst, pc, jump} into the instruction queue. A ROB rollback
//   redirects the PC and discards any in-flight or held instruction.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (low = freeze)
//   icache_req/icache_addr       -> request pulse and address
//   icache_valid/icache_inst     <- response strobe and word
//   pred_pc/pred_inst/pred_target -> predictor query (combinational)
//   pred_next_pc/pred_jump       <- predictor answer
//   iq_full                      <- queue back-pressure
//   iq_push/iq_inst/iq_pc/iq_jump -> queue push
//   rollback/rollback_pc         <- misprediction flush
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_inst,
  output logic [31:0] pred_pc,
  output logic [31:0] pred_inst,
  output logic [31:0] pred_target,
  input  logic [31:0] pred_next_pc,
  input  logic        pred_jump,
  input  logic        iq_full,
  output logic        iq_push,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic        iq_jump,
  input  logic        rollback,
  input  logic [31:0] rollback_pc
);

  typedef enum logic [1:0] {StIdle, StWait, StStall, StFlush} state_e;

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_inst, w_inst_d;
  logic        r_icache_req, w_icache_req_d;
  logic [31:0] r_icache_addr, w_icache_addr_d;
  logic        r_iq_push, w_iq_push_d;
  logic [31:0] r_iq_inst, w_iq_inst_d;
  logic [31:0] r_iq_pc, w_iq_pc_d;
  logic        r_iq_jump, w_iq_jump_d;

  logic [31:0] w_cur_inst;
  logic        w_is_branch, w_is_jal;
  logic [31:0] w_b_imm, w_j_imm;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;
  logic        w_jump;

  // Instruction currently under decode: live response in WAIT, held copy in STALL.
  always_comb begin
    w_cur_inst = 32'h0;
    unique case (r_state)
      StWait:  w_cur_inst = icache_inst;
      StStall: w_cur_inst = r_inst;
      default: w_cur_inst = 32'h0;
    endcase
  end

  always_comb begin
    w_is_branch = (w_cur_inst[6:0] == OpBranch);
    w_is_jal    = (w_cur_inst[6:0] == OpJal);
    w_b_imm     = {{20{w_cur_inst[31]}}, w_cur_inst[7], w_cur_inst[30:25],
                   w_cur_inst[11:8], 1'b0};
    w_j_imm     = {{12{w_cur_inst[31]}}, w_cur_inst[19:12], w_cur_inst[20],
                   w_cur_inst[30:21], 1'b0};
    if (w_is_branch) begin
      w_target = r_pc + w_b_imm;
    end else if (w_is_jal) begin
      w_target = r_pc + w_j_imm;
    end else begin
      w_target = r_pc + 32'd4;
    end
    // JAL is resolved here; only conditional branches follow the predictor.
    if (w_is_jal) begin
      w_next_pc = w_target;
      w_jump    = 1'b1;
    end else if (w_is_branch) begin
      w_next_pc = pred_next_pc;
      w_jump    = pred_jump;
    end else begin
      w_next_pc = r_pc + 32'd4;
      w_jump    = 1'b0;
    end
  end

  assign pred_pc     = r_pc;
  assign pred_inst   = w_cur_inst;
  assign pred_target = w_target;

  always_comb begin
    w_state_d       = r_state;
    w_pc_d          = r_pc;
    w_inst_d        = r_inst;
    w_icache_req_d  = 1'b0;
    w_icache_addr_d = r_icache_addr;
    w_iq_push_d     = 1'b0;
    w_iq_inst_d     = r_iq_inst;
    w_iq_pc_d       = r_iq_pc;
    w_iq_jump_d     = r_iq_jump;

    unique case (r_state)
      StIdle: begin
        w_icache_req_d  = 1'b1;
        w_icache_addr_d = r_pc;
        if (rollback) begin
          // The request leaving this cycle targets the old PC: its response must be dropped.
          w_pc_d    = rollback_pc;
          w_state_d = StFlush;
        end else begin
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (rollback) begin
          w_pc_d    = rollback_pc;
          w_state_d = icache_valid ? StIdle : StFlush;
        end else if (icache_valid) begin
          if (!iq_full) begin
            w_iq_push_d = 1'b1;
            w_iq_inst_d = w_cur_inst;
            w_iq_pc_d   = r_pc;
            w_iq_jump_d = w_jump;
            w_pc_d      = w_next_pc;
            w_state_d   = StIdle;
          end else begin
            w_inst_d  = icache_inst;
            w_state_d = StStall;
          end
        end
      end
      StStall: begin
        if (rollback) begin
          w_pc_d    = rollback_pc;
          w_inst_d  = 32'h0;
          w_state_d = StIdle;
        end else if (!iq_full) begin
          w_iq_push_d = 1'b1;
          w_iq_inst_d = w_cur_inst;
          w_iq_pc_d   = r_pc;
          w_iq_jump_d = w_jump;
          w_pc_d      = w_next_pc;
          w_state_d   = StIdle;
        end
      end
      StFlush: begin
        if (rollback) begin
          w_pc_d = rollback_pc;
        end
        // The stale response retires the outstanding request either way.
        if (icache_valid) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state       <= StIdle;
      r_pc          <= RESET_PC;
      r_inst        <= 32'h0;
      r_icache_req  <= 1'b0;
      r_icache_addr <= 32'h0;
      r_iq_push     <= 1'b0;
      r_iq_inst     <= 32'h0;
      r_iq_pc       <= 32'h0;
      r_iq_jump     <= 1'b0;
    end else if (rdy_in) begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_inst        <= w_inst_d;
      r_icache_req  <= w_icache_req_d;
      r_icache_addr <= w_icache_addr_d;
      r_iq_push     <= w_iq_push_d;
      r_iq_inst     <= w_iq_inst_d;
      r_iq_pc       <= w_iq_pc_d;
      r_iq_jump     <= w_iq_jump_d;
    end else begin
      // Frozen: pulses must not repeat while stalled.
      r_icache_req <= 1'b0;
      r_iq_push    <= 1'b0;
    end
  end

  assign icache_req  = r_icache_req;
  assign icache_addr = r_icache_addr;
  assign iq_push     = r_iq_push;
  assign iq_inst     = r_iq_inst;
  assign iq_pc       = r_iq_pc;
  assign iq_jump     = r_iq_jump;

endmodule
